// File: rtl/cnn_acc_pkg.sv
// Shared constants and width helpers for the CNN accumulator adder tree.
package cnn_acc_pkg;

  localparam int unsigned DEF_NUM_INPUTS = 8;
  localparam int unsigned DEF_IN_WIDTH   = 24;
  localparam int unsigned DEF_OUT_WIDTH  = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 8;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Width needed to sum n lanes of in_w bits without overflow.
  function automatic int unsigned tree_width(input int unsigned in_w, input int unsigned n);
    return in_w + clog2(n);
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: N_OPS operands in, N_OPS/2 pairwise sums out.
// Operands are already at full tree width, so the sums cannot overflow.
module adder_tree_level #(
  parameter int unsigned N_OPS = 8,
  parameter int unsigned OP_W  = 27
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_i,
  input  logic                        last_i,
  input  logic [N_OPS*OP_W-1:0]       data_i,
  output logic                        valid_o,
  output logic                        last_o,
  output logic [(N_OPS/2)*OP_W-1:0]   data_o
);

  localparam int unsigned N_OUT = N_OPS / 2;

  logic [N_OUT*OP_W-1:0] data_d;
  logic [N_OUT*OP_W-1:0] data_q;
  logic                  valid_q;
  logic                  last_q;

  // Pairwise signed add of neighbouring operands.
  always_comb begin
    data_d = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      data_d[k*OP_W +: OP_W] = OP_W'($signed(data_i[(2*k)*OP_W +: OP_W]) +
                                     $signed(data_i[(2*k+1)*OP_W +: OP_W]));
    end
  end

  // Flags shift every cycle; data loads only on a valid slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_i;
      last_q  <= last_i;
      if (valid_i) data_q <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign data_o  = data_q;

endmodule

// File: rtl/accumulator_adder_tree.sv
// Sums lanes 0..active_m1_i through a registered adder tree and accumulates the
// tree results over the beats of a frame, emitting one sum and beat count per frame.
// Optional clamping accumulator and sticky sat_o: define ACCUMULATOR_ADDER_TREE_SAT_EN.
module accumulator_adder_tree
  import cnn_acc_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned SEL_WIDTH  = clog2(NUM_INPUTS),
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_i,
  input  logic                           last_i,
  input  logic [SEL_WIDTH-1:0]           active_m1_i,
  input  logic [NUM_INPUTS*IN_WIDTH-1:0] data_i,
  output logic                           valid_o,
  output logic [OUT_WIDTH-1:0]           sum_o,
  output logic [CNT_WIDTH-1:0]           beat_cnt_o,
  output logic                           sat_o
);

  localparam int unsigned L        = clog2(NUM_INPUTS);
  localparam int unsigned TW       = tree_width(IN_WIDTH, NUM_INPUTS);
  // All tree levels packed in one bus: entry l holds NUM_INPUTS>>l operands.
  localparam int unsigned BUS_W    = (2 * NUM_INPUTS - 1) * TW;
  localparam int unsigned OFF_LAST = TW * (2 * NUM_INPUTS - 2);

  logic [BUS_W-1:0]         tree_bus;
  logic [L:0]               tree_v;
  logic [L:0]               tree_l;

  logic [NUM_INPUTS*TW-1:0] s0_data_d;
  logic [NUM_INPUTS*TW-1:0] s0_data_q;
  logic                     s0_valid_q;
  logic                     s0_last_q;

  logic [OUT_WIDTH-1:0]     tree_sext;
  logic [OUT_WIDTH-1:0]     base;
  logic [OUT_WIDTH-1:0]     acc_d,      acc_q;
  logic [CNT_WIDTH-1:0]     cnt_d,      cnt_q;
  logic                     in_frame_d, in_frame_q;
  logic                     valid_d,    valid_q;
  logic [OUT_WIDTH-1:0]     sum_d,      sum_q;
  logic [CNT_WIDTH-1:0]     beat_cnt_d, beat_cnt_q;

`ifdef ACCUMULATOR_ADDER_TREE_SAT_EN
  localparam logic [OUT_WIDTH-1:0] ACC_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] ACC_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  logic [OUT_WIDTH:0] sum_wide;
  logic               sticky_d, sticky_q;
  logic               sat_d,    sat_q;
`endif

  // Stage 0 input shaping: sign-extend active lanes, zero the rest.
  always_comb begin
    s0_data_d = '0;
    for (int k = 0; k < int'(NUM_INPUTS); k++) begin
      if (SEL_WIDTH'(k) <= active_m1_i) begin
        s0_data_d[k*TW +: TW] = TW'($signed(data_i[k*IN_WIDTH +: IN_WIDTH]));
      end
    end
  end

  // Stage 0 registers; flags shift every cycle, data loads on valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_data_q  <= '0;
    end else begin
      s0_valid_q <= valid_i;
      s0_last_q  <= last_i;
      if (valid_i) s0_data_q <= s0_data_d;
    end
  end

  assign tree_bus[NUM_INPUTS*TW-1:0] = s0_data_q;
  assign tree_v[0] = s0_valid_q;
  assign tree_l[0] = s0_last_q;

  for (genvar l = 0; l < int'(L); l++) begin : g_lvl
    localparam int unsigned N_OPS   = NUM_INPUTS >> l;
    localparam int unsigned OFF_IN  = TW * (2 * NUM_INPUTS - 2 * (NUM_INPUTS >> l));
    localparam int unsigned OFF_OUT = TW * (2 * NUM_INPUTS - 2 * (NUM_INPUTS >> (l + 1)));

    adder_tree_level #(
      .N_OPS (N_OPS),
      .OP_W  (TW)
    ) u_level (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (tree_v[l]),
      .last_i  (tree_l[l]),
      .data_i  (tree_bus[OFF_IN +: N_OPS*TW]),
      .valid_o (tree_v[l+1]),
      .last_o  (tree_l[l+1]),
      .data_o  (tree_bus[OFF_OUT +: (N_OPS/2)*TW])
    );
  end

  assign tree_sext = OUT_WIDTH'($signed(tree_bus[OFF_LAST +: TW]));

  // Frame accumulation, beat counting and per-frame result capture.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    in_frame_d = in_frame_q;
    valid_d    = 1'b0;
    sum_d      = sum_q;
    beat_cnt_d = beat_cnt_q;
    base       = in_frame_q ? acc_q : '0;
`ifdef ACCUMULATOR_ADDER_TREE_SAT_EN
    sticky_d   = sticky_q;
    sat_d      = sat_q;
    sum_wide   = '0;
`endif
    if (tree_v[L]) begin
      if (!in_frame_q)  cnt_d = CNT_WIDTH'(1);
      else if (&cnt_q)  cnt_d = cnt_q;
      else              cnt_d = cnt_q + CNT_WIDTH'(1);
`ifdef ACCUMULATOR_ADDER_TREE_SAT_EN
      sum_wide = {base[OUT_WIDTH-1], base} + {tree_sext[OUT_WIDTH-1], tree_sext};
      sticky_d = in_frame_q ? sticky_q : 1'b0;
      if (sum_wide[OUT_WIDTH] != sum_wide[OUT_WIDTH-1]) begin
        acc_d    = sum_wide[OUT_WIDTH] ? ACC_MIN : ACC_MAX;
        sticky_d = 1'b1;
      end else begin
        acc_d    = sum_wide[OUT_WIDTH-1:0];
      end
`else
      acc_d = base + tree_sext;
`endif
      if (tree_l[L]) begin
        valid_d    = 1'b1;
        sum_d      = acc_d;
        beat_cnt_d = cnt_d;
        in_frame_d = 1'b0;
`ifdef ACCUMULATOR_ADDER_TREE_SAT_EN
        sat_d      = sticky_d;
`endif
      end else begin
        in_frame_d = 1'b1;
      end
    end
  end

  // Accumulate-stage and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      in_frame_q <= 1'b0;
      valid_q    <= 1'b0;
      sum_q      <= '0;
      beat_cnt_q <= '0;
`ifdef ACCUMULATOR_ADDER_TREE_SAT_EN
      sticky_q   <= 1'b0;
      sat_q      <= 1'b0;
`endif
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      in_frame_q <= in_frame_d;
      valid_q    <= valid_d;
      sum_q      <= sum_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef ACCUMULATOR_ADDER_TREE_SAT_EN
      sticky_q   <= sticky_d;
      sat_q      <= sat_d;
`endif
    end
  end

  assign valid_o    = valid_q;
  assign sum_o      = sum_q;
  assign beat_cnt_o = beat_cnt_q;
`ifdef ACCUMULATOR_ADDER_TREE_SAT_EN
  assign sat_o      = sat_q;
`else
  assign sat_o      = 1'b0;
`endif

endmodule

// File: tb/tb_accumulator_adder_tree.sv
// Scoreboard bench for accumulator_adder_tree (default parameters).
module tb_accumulator_adder_tree;

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 24;
  localparam int unsigned OW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned L  = 3;
  localparam longint      MAXV = 64'sd2147483647;
  localparam longint      MINV = -64'sd2147483648;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           valid_i;
  logic           last_i;
  logic [SW-1:0]  active_m1_i;
  logic [N*IW-1:0] data_i;
  logic           valid_o;
  logic [OW-1:0]  sum_o;
  logic [CW-1:0]  beat_cnt_o;
  logic           sat_o;

  accumulator_adder_tree #(
    .NUM_INPUTS (N),
    .IN_WIDTH   (IW),
    .OUT_WIDTH  (OW),
    .SEL_WIDTH  (SW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .last_i      (last_i),
    .active_m1_i (active_m1_i),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .sum_o       (sum_o),
    .beat_cnt_o  (beat_cnt_o),
    .sat_o       (sat_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] sum;
    logic [CW-1:0] cnt;
    logic          sat;
    longint        cyc;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  longint cyc      = 0;

  // Reference model state: frame-level arithmetic on plain integers.
  bit          m_in_frame = 1'b0;
  longint      m_acc      = 0;
  int unsigned m_cnt      = 0;
  bit          m_sticky   = 1'b0;

  logic [OW-1:0] last_sum = '0;
  logic [CW-1:0] last_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [N*IW-1:0] all_lanes(input logic [IW-1:0] v);
    logic [N*IW-1:0] d;
    for (int k = 0; k < int'(N); k++) d[k*IW +: IW] = v;
    return d;
  endfunction

  function automatic logic [N*IW-1:0] rand_lanes();
    logic [N*IW-1:0] d;
    for (int k = 0; k < int'(N); k++) d[k*IW +: IW] = IW'($urandom);
    return d;
  endfunction

  // Issue one beat and advance the model.
  task automatic drive_beat(input bit last, input logic [SW-1:0] am1, input logic [N*IW-1:0] d);
    longint s;
    longint a;
    logic signed [IW-1:0] ln;
    exp_t e;
    s = 0;
    for (int k = 0; k <= int'(am1); k++) begin
      ln = d[k*IW +: IW];
      s += longint'(ln);
    end
    a = (m_in_frame ? m_acc : 0) + s;
    if (!m_in_frame) begin
      m_cnt    = 1;
      m_sticky = 1'b0;
    end else if (m_cnt < 255) begin
      m_cnt++;
    end
`ifdef ACCUMULATOR_ADDER_TREE_SAT_EN
    if (a > MAXV) begin
      a = MAXV; m_sticky = 1'b1;
    end else if (a < MINV) begin
      a = MINV; m_sticky = 1'b1;
    end
`else
    a = longint'(int'(a));
`endif
    m_acc = a;
    if (last) begin
      e.sum = OW'(a);
      e.cnt = CW'(m_cnt);
      e.sat = m_sticky;
      e.cyc = cyc + L + 2;
      exp_q.push_back(e);
      m_in_frame = 1'b0;
    end else begin
      m_in_frame = 1'b1;
    end
    valid_i     = 1'b1;
    last_i      = last;
    active_m1_i = am1;
    data_i      = d;
    @(posedge clk); #1;
  endtask

  // Bubble with garbage on the qualified inputs.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid_i     = 1'b0;
      last_i      = 1'($urandom);
      active_m1_i = SW'($urandom);
      data_i      = rand_lanes();
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    rst_n   = 1'b0;
    valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n      = 1'b1;
    m_in_frame = 1'b0;
  endtask

  // Monitor: pop and compare on every valid_o, check hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_sum = '0;
      last_cnt = '0;
    end else if (valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: valid_o=1 with sum 0x%0h, expected no output", sum_o);
      end else begin
        e = exp_q.pop_front();
        check("sum_o",      64'(sum_o),      64'(e.sum));
        check("beat_cnt_o", 64'(beat_cnt_o), 64'(e.cnt));
        check("sat_o",      64'(sat_o),      64'(e.sat));
        check("latency",    64'(cyc),        64'(e.cyc));
        last_sum = sum_o;
        last_cnt = beat_cnt_o;
      end
    end else begin
      check("sum_hold", 64'(sum_o),      64'(last_sum));
      check("cnt_hold", 64'(beat_cnt_o), 64'(last_cnt));
    end
  end

  initial begin
    int wait_cyc;
    rst_n       = 1'b0;
    valid_i     = 1'b0;
    last_i      = 1'b0;
    active_m1_i = '0;
    data_i      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_o", 64'(valid_o),    64'd0);
    check("rst_sum_o",   64'(sum_o),      64'd0);
    check("rst_cnt_o",   64'(beat_cnt_o), 64'd0);
    check("rst_sat_o",   64'(sat_o),      64'd0);
    rst_n = 1'b1;
    idle(2);

    // Single beat, all lanes 1.
    drive_beat(1'b1, 3'd7, all_lanes(24'd1));
    idle(8);
    // All lanes -1, only lanes 0..2 active.
    drive_beat(1'b1, 3'd2, all_lanes(24'hFFFFFF));
    idle(8);
    // Three beats with a two-cycle bubble.
    drive_beat(1'b0, 3'd3, all_lanes(24'd100));
    drive_beat(1'b0, 3'd3, all_lanes(24'd100));
    idle(2);
    drive_beat(1'b1, 3'd3, all_lanes(24'd100));
    idle(8);
    // Back-to-back single-beat frames.
    drive_beat(1'b1, 3'd7, all_lanes(24'd1));
    drive_beat(1'b1, 3'd7, all_lanes(24'd2));
    idle(8);
    // Frame aborted by reset, then a clean frame.
    drive_beat(1'b0, 3'd7, all_lanes(24'd5));
    drive_beat(1'b0, 3'd7, all_lanes(24'd5));
    pulse_reset();
    drive_beat(1'b1, 3'd7, all_lanes(24'd1));
    idle(8);
    // Positive and negative overflow of the 32-bit accumulator.
    for (int i = 0; i < 40; i++) drive_beat(i == 39, 3'd7, all_lanes(24'h7FFFFF));
    idle(2);
    for (int i = 0; i < 40; i++) drive_beat(i == 39, 3'd7, all_lanes(24'h800000));
    idle(8);
    // Beat count saturation.
    for (int i = 0; i < 300; i++) drive_beat(i == 299, SW'($urandom), rand_lanes());
    idle(8);
    // Random frames with random bubbles.
    for (int f = 0; f < 60; f++) begin
      int len;
      len = int'($urandom_range(1, 6));
      for (int b = 0; b < len; b++) begin
        drive_beat(b == len - 1, SW'($urandom), rand_lanes());
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 50) begin
      idle(1);
      wait_cyc++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d frames still outstanding, expected 0", exp_q.size());
    end
    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
